// File: rtl/triple_debounce_amisha_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : triple_debounce_amisha_pkg                               |
// | Purpose : Shared state encoding and default sizing for the triple  |
// |           switch debouncer.                                        |
// | Ports   : none (package)                                           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package triple_debounce_amisha_pkg;

  // Bit 1 is the debounced level and bit 0 marks a WAIT state, so the
  // outputs decode straight from the state register.
  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_WAIT1 = 2'b01,
    ST_ONE   = 2'b10,
    ST_WAIT0 = 2'b11
  } db_state_t;

  localparam int DEF_DB_CYCLES = 1000000;
  localparam int DEF_CNT_W     = 20;

  function automatic logic state_is_wait(input db_state_t s);
    return s[0];
  endfunction

  function automatic logic state_level(input db_state_t s);
    return s[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/triple_debounce_amisha_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : debounce_chan_amisha                                     |
// | Purpose : One debounce channel: optional 2-flop synchronizer,      |
// |           debounce FSM with stability counter, change pulse.       |
// | Macro   : DB_SYNC_EN - when defined, the raw input passes through  |
// |           a 2-flop synchronizer before the FSM.                    |
// | Ports   : clk, rst (async, active high), sw (raw input),           |
// |           level (debounced), chg (1-cycle toggle pulse),           |
// |           waiting (FSM in a WAIT state)                            |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module debounce_chan_amisha
  import triple_debounce_amisha_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic chg,
  output logic waiting
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_in;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef DB_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], sw};
    end
  end

  assign sync_in = sync_ff[1];
`else
  assign sync_in = sw;
`endif

  // State register; the change pulse is registered alongside so it lines
  // up with the cycle in which the new level first appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ZERO;
      cnt   <= '0;
      chg   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      chg   <= state_level(state_nxt) ^ state_level(state);
    end
  end

  // Next-state logic. The counter is reloaded on every WAIT entry, so a
  // reversal throws away the partial count and the counter never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ZERO: begin
        if (sync_in) begin
          state_nxt = ST_WAIT1;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT1: begin
        if (!sync_in) begin
          state_nxt = ST_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_ONE: begin
        if (!sync_in) begin
          state_nxt = ST_WAIT0;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT0: begin
        if (sync_in) begin
          state_nxt = ST_ONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ZERO;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    level   = state_level(state);
    waiting = state_is_wait(state);
  end

endmodule
`default_nettype wire

// File: rtl/triple_debounce_amisha.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : triple_debounce_amisha                                   |
// | Purpose : Debounces three raw switch inputs feeding the 3-input    |
// |           AND block; reports per-channel change pulses and a       |
// |           global settled flag.                                     |
// | Macro   : DB_SYNC_EN - adds a 2-flop synchronizer per channel.     |
// | Ports   : clk_amisha, reset_amisha (async, active high),           |
// |           sw_a/b/c_amisha (raw), a/b/c_amisha (debounced),         |
// |           chg_amisha[2:0] (bit0=A), all_settled_amisha             |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module triple_debounce_amisha
  import triple_debounce_amisha_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       sw_a_amisha,
  input  logic       sw_b_amisha,
  input  logic       sw_c_amisha,
  output logic       a_amisha,
  output logic       b_amisha,
  output logic       c_amisha,
  output logic [2:0] chg_amisha,
  output logic       all_settled_amisha
);

  logic [2:0] sw_vec;
  logic [2:0] level_vec;
  logic [2:0] waiting_vec;

  assign sw_vec = {sw_c_amisha, sw_b_amisha, sw_a_amisha};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    debounce_chan_amisha #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk     (clk_amisha),
      .rst     (reset_amisha),
      .sw      (sw_vec[i]),
      .level   (level_vec[i]),
      .chg     (chg_amisha[i]),
      .waiting (waiting_vec[i])
    );
  end

  assign a_amisha = level_vec[0];
  assign b_amisha = level_vec[1];
  assign c_amisha = level_vec[2];

  // The WAIT flags are decoded state-register bits, so this NOR is
  // registered with the states.
  assign all_settled_amisha = ~|waiting_vec;

endmodule
`default_nettype wire

// File: doc/triple_debounce_amisha.md
Name: triple_debounce_amisha

Overview:
- Input-conditioning stage that sits directly upstream of the 3-input AND block.
- Takes three raw, bouncing switch/button inputs and produces the clean level signals a_amisha, b_amisha, c_amisha that feed the AND.
- Each channel gets an optional 2-flop synchronizer, then its own debounce FSM with a stability counter, plus one-cycle change pulses and a settled flag.

Parameters:
- DB_CYCLES, 1000000: consecutive stable clocks required before an output changes; legal range 1 .. 2^CNT_W-1.
- CNT_W, 20: width of each channel's stability counter.

Ports:
- clk_amisha  input  1  system clock; all state updates on its rising edge.
- reset_amisha  input  1  asynchronous, active-high reset.
- sw_a_amisha  input  1  raw input, channel A.
- sw_b_amisha  input  1  raw input, channel B.
- sw_c_amisha  input  1  raw input, channel C.
- a_amisha  output  1  debounced level, channel A (to AND input a).
- b_amisha  output  1  debounced level, channel B.
- c_amisha  output  1  debounced level, channel C.
- chg_amisha  output  3  one-cycle pulse when the matching debounced output changes; bit0=A, bit1=B, bit2=C.
- all_settled_amisha  output  1  high when no channel is in a WAIT state.

Behaviour:
- Reset, asynchronous on reset_amisha high:
  - every FSM goes to ZERO; all counters 0; synchronizer flops 0.
  - a/b/c_amisha=0, chg_amisha=3'b000, all_settled_amisha=1.
  - Asserting reset in the middle of a count aborts the count immediately.
- Per-channel FSM; "in" is the synchronized input:
  - ZERO: out=0. in=1 -> WAIT1, cnt<=0.
  - WAIT1: out=0. in=0 -> ZERO. in=1 and cnt==DB_CYCLES-1 -> ONE. Otherwise cnt<=cnt+1.
  - ONE: out=1. in=0 -> WAIT0, cnt<=0.
  - WAIT0: out=1. in=1 -> ONE. in=0 and cnt==DB_CYCLES-1 -> ZERO. Otherwise cnt<=cnt+1.
- Outputs are registered, decoded from the state register; no combinational path from input to output.
- Latency:
  - Let edge k be the edge at which the FSM first samples the new stable value.
  - The output changes after edge k+DB_CYCLES.
  - Measured from the raw pin, add 2 clocks when the synchronizer is present.
- Any reversal during WAIT returns to the previous stable state with no output change and no chg pulse. The next attempt restarts the count at 0; partial counts never accumulate.
- chg_amisha[i] is 1 for exactly the one cycle after the edge at which output i toggles (ZERO<->ONE transitions only).
- all_settled_amisha = NOR of all three channels being in WAIT1/WAIT0, registered with the states.
- Channels are fully independent. Simultaneous transitions on several channels all take effect in the same cycle.
- The counter cannot wrap: it never exceeds DB_CYCLES-1, because it is reloaded on every WAIT entry.
- DB_CYCLES=1: output follows the synchronized input after exactly 1 extra clock.

Optional Feature:
- Macro: DB_SYNC_EN.
- Defined: each raw input passes through a 2-flop synchronizer, reset to 0, before its FSM. Pin-to-output latency is DB_CYCLES+2 clocks.
- Undefined: the FSM samples the raw input directly, for sources already synchronous to clk_amisha. Latency is DB_CYCLES clocks.
- FSM behaviour is otherwise identical in both builds.

Decomposition:
- Shared package: state encoding (ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11) and default DB_CYCLES/CNT_W constants.
- Sub-module debounce_chan_amisha holds one channel (synchronizer, FSM, counter, change pulse). It is instantiated three times.
- The top level contains only the three instances and the all_settled logic.

Test Plan:
Bench setting: DB_CYCLES=8, CNT_W=4, DB_SYNC_EN defined.
1. Reset, then all sw inputs 0 for 20 clocks -> a/b/c=0, chg=000, all_settled=1 throughout.
2. sw_a 0->1 at cycle 0 and held -> a_amisha rises after the 10th rising edge; chg_amisha=001 for exactly that one cycle; all_settled low from cycle 3 until a rises.
3. sw_b high for 5 cycles, then low -> b_amisha stays 0, chg[1] never pulses, all_settled returns to 1.
4. sw_a, sw_b, sw_c all 0->1 on the same cycle -> all three outputs rise on the same cycle, 10 clocks later; chg=111 for one cycle. Release all -> all fall 10 clocks after release.
5. sw_c 0->1 held; reset_amisha pulsed at cycle 6 -> c_amisha stays 0. After reset release the count restarts, and c rises 10 clocks after release (input still 1).
6. sw_a toggled every 3 cycles for 24 cycles, then held 1 -> a_amisha stays 0 during the bounce and rises exactly 10 clocks after the final 0->1 transition.
